// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that sequences writes and reads of one shared
// load-enabled register among NUM_REQ requesters.
module reg_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int IDX_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rdata,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic [WIDTH-1:0]         reg_in,
  output logic                     reg_load,
  input  logic [WIDTH-1:0]         reg_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   pos;
  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [WIDTH-1:0]   reg_in_q;
  logic [WIDTH-1:0]   sel_wdata;
  logic               sel_we;

  // In ACK the current winner is not yet in last_grant, so search from idx
  always_comb begin
    base = (state == ACK) ? idx : last_grant;
    cand = req;
    if (state == ACK) cand[idx] = 1'b0;
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(base) + k) % NUM_REQ);
      if (!found && cand[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
  end

  always_comb begin
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_wdata = wdata[i*WIDTH +: WIDTH];
        sel_we    = we[i];
      end
    end
  end

  always_comb begin
    ack      = '0;
    rdata    = '0;
    reg_load = 1'b0;
    reg_in   = reg_in_q;
    busy     = (state != IDLE);
    grant_id = idx;
    unique case (state)
      ISSUE: begin
        reg_in   = sel_wdata;
        reg_load = sel_we;
      end
      ACK: begin
        ack[idx] = 1'b1;
        rdata    = reg_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      reg_in_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            idx   <= win;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          reg_in_q <= sel_wdata;
          state    <= ACK;
        end
        ACK: begin
          last_grant <= idx;
          if (found) begin
            idx   <= win;
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: directed stimulus pushes
// expected acks, an independent monitor pops and compares them.
module tb_reg_access_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     we;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     ack;
  logic [W-1:0]     rdata;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [W-1:0]     reg_in;
  logic             reg_load;
  logic [W-1:0]     reg_q = '0;

  reg_access_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk      (clk),
    .reset    (rst),
    .req      (req),
    .we       (we),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .grant_id (grant_id),
    .busy     (busy),
    .reg_in   (reg_in),
    .reg_load (reg_load),
    .reg_out  (reg_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_load) reg_q <= reg_in;

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [W-1:0]  rdata;
    logic          load;
    logic [W-1:0]  din;
    logic [IW-1:0] gid;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cnt[N];
  logic          issue_load;
  logic [W-1:0]  issue_in;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] rd,
                      input logic ld, input logic [W-1:0] din);
    exp_t e;
    e.ack   = N'(1) << i;
    e.rdata = rd;
    e.load  = ld;
    e.din   = din;
    e.gid   = IW'(i);
    sbq.push_back(e);
  endtask

  task automatic setw(input int i, input logic w, input logic [W-1:0] d);
    we[i] = w;
    wdata[i*W +: W] = d;
  endtask

  // Monitor: records the ISSUE cycle, compares at each ack
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && ack == '0) begin
        issue_load = reg_load;
        issue_in   = reg_in;
      end
      if (ack != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack", 32'(ack), 32'(mon_e.ack));
          chk("grant_id", 32'(grant_id), 32'(mon_e.gid));
          chk("rdata", 32'(rdata), 32'(mon_e.rdata));
          chk("reg_load", 32'(issue_load), 32'(mon_e.load));
          if (mon_e.load) chk("reg_in", 32'(issue_in), 32'(mon_e.din));
        end
      end
    end
  end

  task automatic run(input int exp_first, input bit gap);
    int  cyc = 0;
    int  last = -1;
    bit  done = 0;
    bit  left;
    for (int i = 0; i < N; i++) req[i] = (cnt[i] > 0);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        if (last < 0 && exp_first > 0) chk("first_latency", 32'(cyc), 32'(exp_first));
        if (last >= 0 && gap) chk("ack_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        for (int i = 0; i < N; i++) if (ack[i] && cnt[i] > 0) cnt[i]--;
      end
      left = 0;
      for (int i = 0; i < N; i++) begin
        req[i] = (cnt[i] > 0);
        if (cnt[i] > 0) left = 1;
      end
      if (!left && !busy && ack == '0) done = 1;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_load", 32'(reg_load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_reg_in", 32'(reg_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    do_reset();

    // single write from requester 2
    setw(2, 1'b1, 16'hBEEF);
    push(2, 16'hBEEF, 1'b1, 16'hBEEF);
    cnt[2] = 1;
    run(2, 0);

    // read from requester 1 returns the stored word
    setw(1, 1'b0, 16'h1234);
    push(1, 16'hBEEF, 1'b0, 16'h0);
    cnt[1] = 1;
    run(2, 0);

    // three simultaneous requesters after reset: order 0,1,3
    do_reset();
    setw(0, 1'b1, 16'h1111);
    setw(1, 1'b0, 16'h2222);
    setw(3, 1'b1, 16'h3333);
    push(0, 16'h1111, 1'b1, 16'h1111);
    push(1, 16'h1111, 1'b0, 16'h0);
    push(3, 16'h3333, 1'b1, 16'h3333);
    cnt[0] = 1; cnt[1] = 1; cnt[3] = 1;
    run(2, 1);

    // set last_grant to 0, then all four twice each
    setw(0, 1'b0, 16'hA000);
    push(0, 16'h3333, 1'b0, 16'h0);
    cnt[0] = 1;
    run(2, 0);
    setw(1, 1'b1, 16'hA001);
    setw(2, 1'b0, 16'hA002);
    setw(3, 1'b1, 16'hA003);
    push(1, 16'hA001, 1'b1, 16'hA001);
    push(2, 16'hA001, 1'b0, 16'h0);
    push(3, 16'hA003, 1'b1, 16'hA003);
    push(0, 16'hA003, 1'b0, 16'h0);
    push(1, 16'hA001, 1'b1, 16'hA001);
    push(2, 16'hA001, 1'b0, 16'h0);
    push(3, 16'hA003, 1'b1, 16'hA003);
    push(0, 16'hA003, 1'b0, 16'h0);
    for (int i = 0; i < N; i++) cnt[i] = 2;
    run(2, 1);

    // reset during ISSUE drops the transaction
    setw(2, 1'b1, 16'h5555);
    req = 4'b0100;
    @(negedge clk);
    chk("mid_issue_busy", 32'(busy), 32'd1);
    chk("mid_issue_load", 32'(reg_load), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_load", 32'(reg_load), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_reg_kept", 32'(reg_q), 32'hA003);
    setw(3, 1'b1, 16'h7777);
    push(3, 16'h7777, 1'b1, 16'h7777);
    cnt[3] = 1;
    run(2, 0);

    // one-cycle req[1] pulse while requester 0 is served
    setw(0, 1'b1, 16'h0F0F);
    push(0, 16'h0F0F, 1'b1, 16'h0F0F);
    req = 4'b0001;
    @(negedge clk);
    chk("pulse_issue_busy", 32'(busy), 32'd1);
    req[1] = 1'b1;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("pulse_busy_low", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("pulse_drain", 32'(sbq.size()), 32'd0);
    chk("pulse_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
